// File: rtl/axi_dw_rd_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_dw_rd_sequencer_if : AR/R handshake bundle for the rd sequencer |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface axi_dw_rd_sequencer_if #(
  parameter int LANE_W = 1
);
  logic              slv_ar_valid_i;
  logic              slv_ar_ready_o;
  logic [7:0]        slv_ar_len_i;
  logic [2:0]        slv_ar_size_i;
  logic              mst_ar_valid_o;
  logic              mst_ar_ready_i;
  logic [7:0]        mst_ar_len_o;
  logic [2:0]        mst_ar_size_o;
  logic              mst_r_valid_i;
  logic              mst_r_last_i;
  logic              mst_r_ready_o;
  logic [LANE_W-1:0] lane_o;
  logic              slv_r_valid_o;
  logic              slv_r_last_o;
  logic              slv_r_ready_i;
  logic              protocol_err_o;

  // master: the sequencer itself; slave: the surrounding environment
  modport master (
    input  slv_ar_valid_i, slv_ar_len_i, slv_ar_size_i,
    output slv_ar_ready_o,
    output mst_ar_valid_o, mst_ar_len_o, mst_ar_size_o,
    input  mst_ar_ready_i,
    input  mst_r_valid_i, mst_r_last_i,
    output mst_r_ready_o,
    output lane_o, slv_r_valid_o, slv_r_last_o, protocol_err_o,
    input  slv_r_ready_i
  );

  modport slave (
    output slv_ar_valid_i, slv_ar_len_i, slv_ar_size_i,
    input  slv_ar_ready_o,
    input  mst_ar_valid_o, mst_ar_len_o, mst_ar_size_o,
    output mst_ar_ready_i,
    output mst_r_valid_i, mst_r_last_i,
    input  mst_r_ready_o,
    input  lane_o, slv_r_valid_o, slv_r_last_o, protocol_err_o,
    output slv_r_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/axi_dw_rd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_dw_rd_sequencer : splits wide AXI reads into narrow sub-bursts  |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module axi_dw_rd_sequencer #(
  parameter int SlvDataWidth = 64,
  parameter int MstDataWidth = 32,
  parameter int MaxReads     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  axi_dw_rd_sequencer_if.master  bus
);
  localparam int         c_ratio    = SlvDataWidth / MstDataWidth;
  localparam int         c_lane_w   = $clog2(c_ratio);
  localparam logic [2:0] c_mst_size = 3'($clog2(MstDataWidth / 8));
  localparam int         c_ptr_w    = (MaxReads > 1) ? $clog2(MaxReads) : 1;
  localparam int         c_cnt_w    = $clog2(MaxReads + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } ar_state_e;

  ar_state_e           r_state;
  logic [11:0]         r_remaining;
  logic [2:0]          r_mst_size;

  logic [2:0]          r_q_flog  [MaxReads];
  logic [7:0]          r_q_len   [MaxReads];
  logic [11:0]         r_q_total [MaxReads];
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;

  logic [c_lane_w-1:0] r_lane;
  logic [11:0]         r_narrow;
  logic [7:0]          r_sbeat;
  logic                r_slv_valid;
  logic                r_slv_last;
  logic                r_err;

  logic                w_up;
  logic [2:0]          w_f_log;
  logic [2:0]          w_mst_size;
  logic [11:0]         w_beats;
  logic [11:0]         w_total;
  logic [11:0]         w_ar_chunk;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_slv_ar_ready;
  logic                w_slv_ar_hs;
  logic                w_mst_ar_hs;
  logic [2:0]          w_head_flog;
  logic [7:0]          w_head_len;
  logic [11:0]         w_head_total;
  logic [c_lane_w-1:0] w_lane_max;
  logic                w_mst_r_ready;
  logic                w_mst_r_hs;
  logic                w_slv_r_hs;
  logic                w_exp_last;

  // Upsizing factor f is kept as log2(f) so T is a plain shift.
  assign w_up       = bus.slv_ar_size_i > c_mst_size;
  assign w_f_log    = w_up ? (bus.slv_ar_size_i - c_mst_size) : 3'd0;
  assign w_mst_size = w_up ? c_mst_size : bus.slv_ar_size_i;
  assign w_beats    = {4'd0, bus.slv_ar_len_i} + 12'd1;
  assign w_total    = w_beats << w_f_log;

  assign w_ar_chunk = (r_remaining > 12'd256) ? 12'd256 : r_remaining;
  assign w_full     = (r_count == c_cnt_w'(MaxReads));
  assign w_empty    = (r_count == '0);
  assign w_slv_r_hs = r_slv_valid & bus.slv_r_ready_i;
  assign w_pop      = w_slv_r_hs & r_slv_last;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_slv_ar_ready = (r_state == ST_IDLE) && (!w_full || w_pop);
  assign w_slv_ar_hs    = bus.slv_ar_valid_i & w_slv_ar_ready;
  assign w_mst_ar_hs    = (r_state == ST_ISSUE) & bus.mst_ar_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_remaining <= 12'd0;
      r_mst_size  <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_slv_ar_hs) begin
            r_remaining <= w_total;
            r_mst_size  <= w_mst_size;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_mst_ar_hs) begin
            r_remaining <= r_remaining - w_ar_chunk;
            if (r_remaining == w_ar_chunk) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_slv_ar_hs) begin
      r_q_flog[r_wptr]  <= w_f_log;
      r_q_len[r_wptr]   <= bus.slv_ar_len_i;
      r_q_total[r_wptr] <= w_total;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_slv_ar_hs) begin
        r_wptr <= (r_wptr == c_ptr_w'(MaxReads - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_ptr_w'(MaxReads - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_slv_ar_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_flog   = r_q_flog[r_rptr];
  assign w_head_len    = r_q_len[r_rptr];
  assign w_head_total  = r_q_total[r_rptr];
  assign w_lane_max    = c_lane_w'((12'd1 << w_head_flog) - 12'd1);
  assign w_mst_r_ready = !w_empty && !r_slv_valid;
  assign w_mst_r_hs    = bus.mst_r_valid_i & w_mst_r_ready;

  // Master bursts are at most 256 beats, so last falls on every 256th beat
  // and on the final narrow beat of the transaction.
  assign w_exp_last = (r_narrow[7:0] == 8'hFF) || (r_narrow == w_head_total - 12'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lane      <= '0;
      r_narrow    <= 12'd0;
      r_sbeat     <= 8'd0;
      r_slv_valid <= 1'b0;
      r_slv_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_mst_r_hs) begin
        r_narrow <= r_narrow + 12'd1;
        if (r_lane == w_lane_max) begin
          r_lane      <= '0;
          r_slv_valid <= 1'b1;
          r_slv_last  <= (r_sbeat == w_head_len);
        end else begin
          r_lane <= r_lane + 1'b1;
        end
        if (bus.mst_r_last_i != w_exp_last) begin
          r_err <= 1'b1;
        end
      end
      if (w_slv_r_hs) begin
        r_slv_valid <= 1'b0;
        r_slv_last  <= 1'b0;
        if (r_slv_last) begin
          r_sbeat  <= 8'd0;
          r_narrow <= 12'd0;
        end else begin
          r_sbeat <= r_sbeat + 8'd1;
        end
      end
    end
  end

  assign bus.slv_ar_ready_o = w_slv_ar_ready;
  assign bus.mst_ar_valid_o = (r_state == ST_ISSUE);
  assign bus.mst_ar_len_o   = 8'(w_ar_chunk - 12'd1);
  assign bus.mst_ar_size_o  = r_mst_size;
  assign bus.mst_r_ready_o  = w_mst_r_ready;
  assign bus.lane_o         = r_lane;
  assign bus.slv_r_valid_o  = r_slv_valid;
  assign bus.slv_r_last_o   = r_slv_last;
  assign bus.protocol_err_o = r_err;
endmodule
`default_nettype wire

// File: tb/tb_axi_dw_rd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi_dw_rd_sequencer : directed bench for axi_dw_rd_sequencer     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_axi_dw_rd_sequencer;
  localparam int LANE_W = 1;

  logic clk = 1'b0;
  logic rst;
  int   n_pass    = 0;
  int   n_total   = 0;
  int   n_timeout = 0;

  axi_dw_rd_sequencer_if #(.LANE_W(LANE_W)) ifc ();

  axi_dw_rd_sequencer #(
    .SlvDataWidth(64),
    .MstDataWidth(32),
    .MaxReads    (4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.slv_ar_valid_i = 1'b0;
    ifc.slv_ar_len_i   = 8'd0;
    ifc.slv_ar_size_i  = 3'd0;
    ifc.mst_ar_ready_i = 1'b0;
    ifc.mst_r_valid_i  = 1'b0;
    ifc.mst_r_last_i   = 1'b0;
    ifc.slv_r_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic slv_ar(input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    ifc.slv_ar_valid_i = 1'b1;
    ifc.slv_ar_len_i   = len;
    ifc.slv_ar_size_i  = size;
    #1;
    while (!ifc.slv_ar_ready_o && n < 100) begin cyc(); n++; end
    if (!ifc.slv_ar_ready_o) n_timeout++;
    cyc();
    ifc.slv_ar_valid_i = 1'b0;
  endtask

  task automatic mst_ar(output logic [7:0] len, output logic [2:0] size);
    int n = 0;
    while (!ifc.mst_ar_valid_o && n < 100) begin cyc(); n++; end
    if (!ifc.mst_ar_valid_o) n_timeout++;
    len  = ifc.mst_ar_len_o;
    size = ifc.mst_ar_size_o;
    ifc.mst_ar_ready_i = 1'b1;
    cyc();
    ifc.mst_ar_ready_i = 1'b0;
  endtask

  task automatic mst_r(input logic last, output logic [LANE_W-1:0] lane);
    int n = 0;
    ifc.mst_r_valid_i = 1'b1;
    ifc.mst_r_last_i  = last;
    #1;
    while (!ifc.mst_r_ready_o && n < 100) begin cyc(); n++; end
    if (!ifc.mst_r_ready_o) n_timeout++;
    lane = ifc.lane_o;
    cyc();
    ifc.mst_r_valid_i = 1'b0;
    ifc.mst_r_last_i  = 1'b0;
  endtask

  task automatic slv_r(output logic last);
    int n = 0;
    while (!ifc.slv_r_valid_o && n < 100) begin cyc(); n++; end
    if (!ifc.slv_r_valid_o) n_timeout++;
    last = ifc.slv_r_last_o;
    ifc.slv_r_ready_i = 1'b1;
    cyc();
    ifc.slv_r_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    do_reset();
    #1;
    got = {ifc.slv_ar_ready_o, ifc.mst_ar_valid_o, ifc.mst_r_ready_o, ifc.slv_r_valid_o,
           ifc.slv_r_last_o, ifc.lane_o, ifc.protocol_err_o};
    n_total++;
    if (got !== 7'b1000000) $display("FAIL reset_outputs: got %b expected %b", got, 7'b1000000);
    else n_pass++;
  endtask

  task automatic test_upsize();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    int t0 = n_timeout;
    do_reset();
    slv_ar(8'd3, 3'd3);
    mst_ar(len, size);
    n_total++;
    if (len !== 8'd7) $display("FAIL upsize_ar_len: got %0d expected 7", len); else n_pass++;
    n_total++;
    if (size !== 3'd2) $display("FAIL upsize_ar_size: got %0d expected 2", size); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      mst_r(i == 7, lane);
      n_total++;
      if (lane !== 1'(i % 2)) $display("FAIL upsize_lane%0d: got %0d expected %0d", i, lane, i % 2);
      else n_pass++;
      if (i % 2 == 1) begin
        slv_r(last);
        n_total++;
        if (last !== (i == 7)) $display("FAIL upsize_last%0d: got %0d expected %0d", i, last, i == 7);
        else n_pass++;
      end
    end
    n_total++;
    if ({ifc.protocol_err_o, ifc.slv_ar_ready_o, ifc.mst_r_ready_o} !== 3'b010)
      $display("FAIL upsize_end_state: got %b expected 010",
               {ifc.protocol_err_o, ifc.slv_ar_ready_o, ifc.mst_r_ready_o});
    else n_pass++;
    n_total++;
    if (n_timeout - t0 !== 0) $display("FAIL upsize_timeout: got %0d expected 0", n_timeout - t0);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    int t0 = n_timeout;
    do_reset();
    slv_ar(8'd5, 3'd2);
    mst_ar(len, size);
    n_total++;
    if ({len, size} !== {8'd5, 3'd2}) $display("FAIL pass_ar: got len %0d size %0d expected 5/2", len, size);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      mst_r(i == 5, lane);
      slv_r(last);
      n_total++;
      if ({lane, last} !== {1'b0, 1'(i == 5)})
        $display("FAIL pass_beat%0d: got lane %0d last %0d expected lane 0 last %0d", i, lane, last, i == 5);
      else n_pass++;
    end
    n_total++;
    if (ifc.protocol_err_o !== 1'b0 || n_timeout - t0 !== 0)
      $display("FAIL pass_err: got err %0d timeouts %0d expected 0", ifc.protocol_err_o, n_timeout - t0);
    else n_pass++;
  endtask

  task automatic test_long_burst();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    int lane_bad = 0, last_bad = 0;
    int t0 = n_timeout;
    do_reset();
    slv_ar(8'd255, 3'd3);
    mst_ar(len, size);
    n_total++;
    if (len !== 8'd255 || ifc.mst_ar_valid_o !== 1'b1 || ifc.slv_ar_ready_o !== 1'b0)
      $display("FAIL long_ar1: got len %0d next_valid %0d slv_ready %0d expected 255/1/0",
               len, ifc.mst_ar_valid_o, ifc.slv_ar_ready_o);
    else n_pass++;
    mst_ar(len, size);
    n_total++;
    if (len !== 8'd255 || ifc.mst_ar_valid_o !== 1'b0)
      $display("FAIL long_ar2: got len %0d valid_after %0d expected 255/0", len, ifc.mst_ar_valid_o);
    else n_pass++;
    for (int i = 0; i < 512; i++) begin
      mst_r(i == 255 || i == 511, lane);
      if (lane !== 1'(i % 2)) lane_bad++;
      if (i % 2 == 1) begin
        slv_r(last);
        if (last !== (i == 511)) last_bad++;
      end
    end
    n_total++;
    if (lane_bad !== 0) $display("FAIL long_lanes: got %0d bad expected 0", lane_bad); else n_pass++;
    n_total++;
    if (last_bad !== 0) $display("FAIL long_last: got %0d bad expected 0", last_bad); else n_pass++;
    n_total++;
    if (ifc.protocol_err_o !== 1'b0) $display("FAIL long_err: got %0d expected 0", ifc.protocol_err_o);
    else n_pass++;
    n_total++;
    if (n_timeout - t0 !== 0) $display("FAIL long_timeout: got %0d expected 0", n_timeout - t0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    int t0 = n_timeout;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      slv_ar(8'd0, 3'd2);
      mst_ar(len, size);
    end
    n_total++;
    if (ifc.slv_ar_ready_o !== 1'b0) $display("FAIL b2b_full_ready: got %0d expected 0", ifc.slv_ar_ready_o);
    else n_pass++;
    mst_r(1'b1, lane);
    n_total++;
    if ({ifc.slv_r_valid_o, ifc.slv_r_last_o, ifc.slv_ar_ready_o} !== 3'b110)
      $display("FAIL b2b_pending: got %b expected 110",
               {ifc.slv_r_valid_o, ifc.slv_r_last_o, ifc.slv_ar_ready_o});
    else n_pass++;
    ifc.slv_ar_valid_i = 1'b1;
    ifc.slv_ar_len_i   = 8'd1;
    ifc.slv_ar_size_i  = 3'd2;
    ifc.slv_r_ready_i  = 1'b1;
    #1;
    n_total++;
    if (ifc.slv_ar_ready_o !== 1'b1) $display("FAIL b2b_pop_ready: got %0d expected 1", ifc.slv_ar_ready_o);
    else n_pass++;
    cyc();
    ifc.slv_ar_valid_i = 1'b0;
    ifc.slv_r_ready_i  = 1'b0;
    mst_ar(len, size);
    n_total++;
    if (len !== 8'd1 || ifc.slv_ar_ready_o !== 1'b0)
      $display("FAIL b2b_fifth: got len %0d slv_ready %0d expected 1/0", len, ifc.slv_ar_ready_o);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      mst_r(i != 3, lane);
      slv_r(last);
      n_total++;
      if (last !== 1'(i != 3)) $display("FAIL b2b_drain%0d: got %0d expected %0d", i, last, i != 3);
      else n_pass++;
    end
    n_total++;
    if ({ifc.protocol_err_o, ifc.slv_ar_ready_o, ifc.mst_r_ready_o} !== 3'b010 || n_timeout - t0 !== 0)
      $display("FAIL b2b_end: got %b timeouts %0d expected 010 and 0",
               {ifc.protocol_err_o, ifc.slv_ar_ready_o, ifc.mst_r_ready_o}, n_timeout - t0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    int t0 = n_timeout;
    do_reset();
    slv_ar(8'd0, 3'd3);
    mst_ar(len, size);
    mst_r(1'b0, lane);
    mst_r(1'b1, lane);
    ifc.mst_r_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({ifc.slv_r_valid_o, ifc.mst_r_ready_o} !== 2'b10)
        $display("FAIL bp_hold%0d: got valid/ready %b expected 10", i, {ifc.slv_r_valid_o, ifc.mst_r_ready_o});
      else n_pass++;
      cyc();
    end
    ifc.mst_r_valid_i = 1'b0;
    slv_r(last);
    n_total++;
    if (last !== 1'b1 || n_timeout - t0 !== 0)
      $display("FAIL bp_last: got %0d timeouts %0d expected 1 and 0", last, n_timeout - t0);
    else n_pass++;
  endtask

  task automatic test_protocol_err();
    logic [7:0] len; logic [2:0] size; logic [LANE_W-1:0] lane; logic last;
    logic [6:0] got;
    int t0 = n_timeout;
    do_reset();
    slv_ar(8'd3, 3'd3);
    mst_ar(len, size);
    for (int i = 0; i < 8; i++) begin
      mst_r(i == 2 || i == 7, lane);
      if (i == 1) begin
        n_total++;
        if (ifc.protocol_err_o !== 1'b0) $display("FAIL err_early: got %0d expected 0", ifc.protocol_err_o);
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (ifc.protocol_err_o !== 1'b1) $display("FAIL err_set: got %0d expected 1", ifc.protocol_err_o);
        else n_pass++;
      end
      if (i % 2 == 1) begin
        slv_r(last);
        n_total++;
        if (last !== (i == 7)) $display("FAIL err_flow%0d: got %0d expected %0d", i, last, i == 7);
        else n_pass++;
      end
    end
    n_total++;
    if (ifc.protocol_err_o !== 1'b1) $display("FAIL err_sticky: got %0d expected 1", ifc.protocol_err_o);
    else n_pass++;
    slv_ar(8'd3, 3'd3);
    mst_ar(len, size);
    mst_r(1'b0, lane);
    mst_r(1'b0, lane);
    slv_r(last);
    mst_r(1'b0, lane);
    n_total++;
    if (ifc.lane_o !== 1'b1) $display("FAIL err_midlane: got %0d expected 1", ifc.lane_o);
    else n_pass++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      got = {ifc.slv_ar_ready_o, ifc.mst_ar_valid_o, ifc.mst_r_ready_o, ifc.slv_r_valid_o,
             ifc.slv_r_last_o, ifc.lane_o, ifc.protocol_err_o};
      n_total++;
      if (got !== 7'b1000000) $display("FAIL midreset%0d: got %b expected %b", k, got, 7'b1000000);
      else n_pass++;
      cyc();
    end
    n_total++;
    if (n_timeout - t0 !== 0) $display("FAIL err_timeout: got %0d expected 0", n_timeout - t0);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_upsize();
    test_passthrough();
    test_long_burst();
    test_back_to_back();
    test_backpressure();
    test_protocol_err();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_dw_rd_sequencer.md
AXI_DW_RD_SEQUENCER -- requirements
Module: axi_dw_rd_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_i clocks all state; rst_i is sampled only on the rising edge of clk_i.
REQ-002 Parameter SlvDataWidth SHALL default to 64 and give the slave-port data width in bits.
REQ-003 Parameter MstDataWidth SHALL default to 32 and give the master-port data width in bits; Ratio = SlvDataWidth/MstDataWidth, a power of two, 2..8.
REQ-004 Parameter MaxReads SHALL default to 4 and give the maximum number of outstanding slave read transactions; legal range 1..16.
REQ-005 Ports SHALL be (name dir width meaning): clk_i in 1 clock; rst_i in 1 sync reset; slv_ar_valid_i in 1; slv_ar_ready_o out 1; slv_ar_len_i in 8 slave burst length-1; slv_ar_size_i in 3 slave beat size log2 bytes.
REQ-006 Further ports: mst_ar_valid_o out 1; mst_ar_ready_i in 1; mst_ar_len_o out 8; mst_ar_size_o out 3; mst_r_valid_i in 1; mst_r_last_i in 1; mst_r_ready_o out 1.
REQ-007 Further ports: lane_o out log2(Ratio) narrow lane of current master R beat; slv_r_valid_o out 1 wide beat complete; slv_r_last_o out 1; slv_r_ready_i in 1; protocol_err_o out 1 sticky error.

Function
REQ-008 Per slave AR: MstSize = log2(MstDataWidth/8); mst size = min(slv_ar_size_i, MstSize); f = 2^(slv_ar_size_i - MstSize) if slv_ar_size_i > MstSize, else 1; total narrow beats T = (slv_ar_len_i+1)*f, 12-bit unsigned.
REQ-009 AR FSM SHALL have states IDLE and ISSUE; slv_ar_ready_o = 1 only in IDLE with tracking FIFO not full.
REQ-010 On slave AR handshake the block SHALL load T remaining, push {f, slv_ar_len_i, T} into the tracking FIFO (depth MaxReads), and enter ISSUE next cycle.
REQ-011 In ISSUE, mst_ar_valid_o = 1, mst_ar_len_o = min(remaining,256)-1, mst_ar_size_o per REQ-008, all held stable until mst_ar_ready_i.
REQ-012 On master AR handshake remaining SHALL decrease by mst_ar_len_o+1; if result is 0 FSM returns to IDLE, else stays in ISSUE with next sub-burst presented the following cycle.
REQ-013 R tracker SHALL operate on FIFO head only; mst_r_ready_o = FIFO not empty AND slv_r_valid_o = 0.
REQ-014 On each master R handshake: lane_o = current lane counter; lane counter increments; narrow index increments.
REQ-015 When lane counter reaches f-1 on a handshake: lane counter clears, slv_r_valid_o registers to 1 next cycle, slv_r_last_o = (slave beat counter == head len).
REQ-016 slv_r_valid_o/slv_r_last_o SHALL hold until slv_r_ready_i; on that handshake valid clears; slave beat counter increments, or on last clears and FIFO head pops.
REQ-017 Expected master last = (narrow index+1) mod 256 == 0 OR narrow index == T-1; any mismatch with mst_r_last_i on a handshake SHALL set protocol_err_o, cleared only by reset; data flow continues unaffected.
REQ-018 Slave AR acceptance and FIFO pop in the same cycle SHALL be supported; occupancy unchanged.
REQ-019 Addresses are size-aligned; lane_o is not address-offset adjusted.

Reset
REQ-020 While rst_i = 1 at a clock edge: AR FSM to IDLE, FIFO emptied, all counters 0, protocol_err_o 0.
REQ-021 After reset: slv_ar_ready_o = 1, mst_ar_valid_o = 0, mst_r_ready_o = 0, slv_r_valid_o = 0, slv_r_last_o = 0, lane_o = 0.
REQ-022 Reset mid-burst SHALL discard all in-flight state; no residual valid asserted in the cycle after reset.

Verification
REQ-023 AR len=3 size=3 -> one mst AR len=7 size=2; 8 mst R beats, lane_o 0,1,0,1... -> 4 slv_r_valid pulses, slv_r_last_o on 4th.
REQ-024 AR len=5 size=2 -> mst AR len=5 size=2; each mst R beat yields one slv beat, lane_o = 0, last on 6th.
REQ-025 AR len=255 size=3 -> two mst ARs len=255; mst_r_last_i at beats 256 and 512 gives no error; slv_r_last_o after beat 512.
REQ-026 MaxReads=4: four ARs accepted back-to-back; fifth sees slv_ar_ready_o = 0 until first slv_r_last handshake; accepted same cycle as pop.
REQ-027 slv_r_ready_i held low 3 cycles on a complete beat -> slv_r_valid_o held, mst_r_ready_o = 0 for those cycles.
REQ-028 mst_r_last_i = 1 on beat 3 of an 8-beat burst -> protocol_err_o = 1 next cycle, held; rst_i pulse mid-burst -> all outputs per REQ-021.
